// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - receive-side sequence checker: acquire, lock, verify, count errors
module sequence_checker #(
    parameter int              W        = 3,
    parameter int              LEN      = 6,
    parameter logic [W*LEN-1:0] SEQ     = 18'b100_110_111_011_001_000,
    parameter int              LOCK_CNT = 3,
    parameter int              MISS_MAX = 2,
    parameter int              ERR_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [W-1:0]            din,
    input  logic                    clr_cnt,
    output logic                    locked,
    output logic                    err,
    output logic                    period_done,
    output logic [ERR_W-1:0]        err_cnt,
    output logic [$clog2(LEN)-1:0]  exp_idx
);

    localparam int IW = $clog2(LEN);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = $clog2(MISS_MAX + 1);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]    state;
    logic [MW-1:0] match_cnt;
    logic [XW-1:0] miss_cnt;

    logic          found;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] hit_next;
    logic [IW-1:0] idx_next;
    logic [W-1:0]  exp_entry;
    logic          match;

    // Scan from the top down so the lowest matching index wins on duplicates.
    always_comb begin
        found   = 1'b0;
        hit_idx = '0;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (din == SEQ[W*i +: W]) begin
                found   = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign hit_next  = (hit_idx == IW'(LEN - 1)) ? '0 : hit_idx + IW'(1);
    assign idx_next  = (exp_idx == IW'(LEN - 1)) ? '0 : exp_idx + IW'(1);
    assign exp_entry = SEQ[W*exp_idx +: W];
    assign match     = (din == exp_entry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            err         <= 1'b0;
            period_done <= 1'b0;
            err_cnt     <= '0;
            exp_idx     <= '0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
        end else begin
            err         <= 1'b0;
            period_done <= 1'b0;
            if (en) begin
                case (state)
                    SEARCH: begin
                        if (found) begin
                            exp_idx   <= hit_next;
                            match_cnt <= MW'(1);
                            if (LOCK_CNT == 1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (match) begin
                            exp_idx   <= idx_next;
                            match_cnt <= match_cnt + MW'(1);
                            if (match_cnt == MW'(LOCK_CNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            state     <= SEARCH;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // The pointer free-runs while locked so a slipped sample costs one error, not a realign.
                        exp_idx <= idx_next;
                        if (match) begin
                            miss_cnt    <= '0;
                            period_done <= (exp_idx == IW'(LEN - 1));
                        end else begin
                            err <= 1'b1;
                            if (miss_cnt == XW'(MISS_MAX - 1)) begin
                                state     <= SEARCH;
                                locked    <= 1'b0;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + XW'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (en && state == LOCKED && !match && err_cnt != {ERR_W{1'b1}}) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - directed-vector bench for sequence_checker
module tb_sequence_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] din;
    logic       clr_cnt;

    logic       locked, err, period_done;
    logic [7:0] err_cnt;
    logic [2:0] exp_idx;
    logic       s_locked, s_err, s_period_done;
    logic [1:0] s_err_cnt;
    logic [2:0] s_exp_idx;

    int nvec = 0;
    int nmis = 0;
    int pos  = 0;
    int pd_seen;
    int pat [6] = '{0, 1, 3, 7, 6, 4};

    always #5 clk = ~clk;

    sequence_checker dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .period_done(period_done),
        .err_cnt(err_cnt), .exp_idx(exp_idx)
    );

    sequence_checker #(.ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
        .locked(s_locked), .err(s_err), .period_done(s_period_done),
        .err_cnt(s_err_cnt), .exp_idx(s_exp_idx)
    );

    task automatic check(input string tag, input int got, input int want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic apply(input logic e, input logic [2:0] d, input logic c);
        en      = e;
        din     = d;
        clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #2;
        check("rst_locked", int'(locked), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_exp_idx", int'(exp_idx), 0);
        rst = 1'b0;
        pos = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = '0; clr_cnt = 1'b0;
        #100;
        check("t1_locked", int'(locked), 0);
        check("t1_err", int'(err), 0);
        check("t1_pd", int'(period_done), 0);
        check("t1_err_cnt", int'(err_cnt), 0);
        check("t1_exp_idx", int'(exp_idx), 0);
        rst = 1'b0;

        // Clean pattern from the start: lock on the third sample.
        pd_seen = 0;
        for (int k = 0; k < 12; k++) begin
            apply(1'b1, 3'(pat[k % 6]), 1'b0);
            check("t2_locked", int'(locked), (k >= 2) ? 1 : 0);
            check("t2_pd", int'(period_done), (k % 6 == 5) ? 1 : 0);
            check("t2_err", int'(err), 0);
            check("t2_exp_idx", int'(exp_idx), (k + 1) % 6);
            pd_seen += int'(period_done);
            if (k == 2) check("t2_lock_idx", int'(exp_idx), 3);
        end
        check("t2_pd_count", pd_seen, 2);

        // Single error while locked.
        apply(1'b1, 3'b000, 1'b0);
        apply(1'b1, 3'b001, 1'b0);
        apply(1'b1, 3'b101, 1'b0);
        check("t4_err", int'(err), 1);
        check("t4_err_cnt", int'(err_cnt), 1);
        check("t4_locked", int'(locked), 1);
        check("t4_exp_idx", int'(exp_idx), 3);
        apply(1'b1, 3'b111, 1'b0);
        check("t4_next_err", int'(err), 0);
        check("t4_next_idx", int'(exp_idx), 4);
        apply(1'b1, 3'b110, 1'b0);
        apply(1'b1, 3'b100, 1'b0);
        check("t4_pd", int'(period_done), 1);
        check("t4_wrap_idx", int'(exp_idx), 0);

        // Two consecutive errors drop lock; counter cleared first.
        apply(1'b0, 3'b101, 1'b1);
        check("t5_clr", int'(err_cnt), 0);
        check("t5_en0_err", int'(err), 0);
        apply(1'b1, 3'b000, 1'b0);
        apply(1'b1, 3'b001, 1'b0);
        apply(1'b1, 3'b101, 1'b0);
        check("t5_err1", int'(err), 1);
        check("t5_locked1", int'(locked), 1);
        apply(1'b1, 3'b101, 1'b0);
        check("t5_err2", int'(err), 1);
        check("t5_err_cnt", int'(err_cnt), 2);
        check("t5_unlocked", int'(locked), 0);
        check("t5_idx", int'(exp_idx), 4);
        apply(1'b1, 3'b111, 1'b0);
        check("t5_rl1_locked", int'(locked), 0);
        apply(1'b1, 3'b110, 1'b0);
        check("t5_rl2_err", int'(err), 0);
        apply(1'b1, 3'b100, 1'b0);
        check("t5_relocked", int'(locked), 1);
        check("t5_rl_pd", int'(period_done), 0);
        check("t5_rl_idx", int'(exp_idx), 0);
        check("t5_cnt_hold", int'(err_cnt), 2);

        // Mid-pattern acquisition after an asynchronous reset.
        @(posedge clk);
        #1;
        async_reset();
        apply(1'b1, 3'b111, 1'b0);
        check("t3_idx1", int'(exp_idx), 4);
        apply(1'b1, 3'b110, 1'b0);
        apply(1'b1, 3'b100, 1'b0);
        check("t3_locked", int'(locked), 1);
        check("t3_idx", int'(exp_idx), 0);
        check("t3_pd", int'(period_done), 0);
        apply(1'b1, 3'b000, 1'b0);
        check("t3_err", int'(err), 0);
        check("t3_idx2", int'(exp_idx), 1);
        pos = 1;

        // Five isolated errors: 8-bit count reaches 5, 2-bit count saturates at 3.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 6; j++) begin
                apply(1'b1, (j == 0) ? 3'b101 : 3'(pat[pos]), 1'b0);
                pos = (pos + 1) % 6;
                if (j == 0) check("t6_err", int'(err), 1);
            end
        end
        check("t6_cnt5", int'(err_cnt), 5);
        check("t6_sat", int'(s_err_cnt), 3);
        check("t6_locked", int'(locked), 1);
        check("t6_idx", int'(exp_idx), pos);

        // Clear wins over a same-cycle increment; err still pulses.
        apply(1'b1, 3'b101, 1'b1);
        pos = (pos + 1) % 6;
        check("t6_clr_err", int'(err), 1);
        check("t6_clr_cnt", int'(err_cnt), 0);
        check("t6_clr_sat", int'(s_err_cnt), 0);

        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 3'b101, 1'b0);
            check("t6_en0_idx", int'(exp_idx), pos);
            check("t6_en0_locked", int'(locked), 1);
            check("t6_en0_err", int'(err), 0);
        end

        apply(1'b1, 3'(pat[pos]), 1'b0);
        pos = (pos + 1) % 6;
        check("t6_resume_err", int'(err), 0);
        apply(1'b1, 3'b101, 1'b0);
        check("t6_pre_rst_cnt", int'(err_cnt), 1);
        check("t6_pre_rst_lock", int'(locked), 1);
        async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
